// File: rtl/conv_pkg.sv
// Shared definitions for the command-to-APB master.
// Holds the FSM state encoding and the APB phase constants. A phase is the
// {psel, penable} pair the master drives while in a given state, so the FSM
// sets both wires with one assignment and never drives a combination that
// APB does not allow.
package conv_pkg;

  // Master FSM states: wait for a command, APB setup, APB access, hold the response
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic psel;
    logic penable;
  } apb_phase_t;

  localparam apb_phase_t PHASE_IDLE   = '{psel: 1'b0, penable: 1'b0};
  localparam apb_phase_t PHASE_SETUP  = '{psel: 1'b1, penable: 1'b0};
  localparam apb_phase_t PHASE_ACCESS = '{psel: 1'b1, penable: 1'b1};

endpackage

// File: rtl/conv_apb_master.sv
// Command-to-APB master with completer timeout.
// A command (write flag, address, write data) is accepted with a valid/ready
// handshake. The master runs one APB transfer and returns a response
// (read data, error, timeout) that it holds until a second valid/ready
// handshake consumes it.
//
// Ports
//   clk_i, reset_i        single rising-edge clock, synchronous active-high reset
//   cmd_valid_i/ready_o   command handshake
//   cmd_write_i           1 = write, 0 = read
//   cmd_addr_i            target address (ADDR_WIDTH bits)
//   cmd_wdata_i           write data, ignored for reads
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data, 0 for writes and timeouts
//   rsp_err_o             PSLVERR from the completer, or timeout
//   rsp_timeout_o         transfer aborted because PREADY never came
//   paddr_o, pwrite_o, pwdata_o, psel_o, penable_o   APB request
//   prdata_i, pready_i, pslverr_i                    APB completer response
//
// Every output comes straight from a flop, so no input reaches an output
// through combinational logic.
module conv_apb_master
  import conv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_WIDTH     = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic                  pwrite_o,
  output logic [31:0]           pwdata_o,
  output logic                  psel_o,
  output logic                  penable_o,
  input  logic [31:0]           prdata_i,
  input  logic                  pready_i,
  input  logic                  pslverr_i
);

  // The wait counter only has to reach TIMEOUT_CYCLES-1, so it is sized from that value
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q;
  apb_phase_t              phase_q;
  logic [WAIT_W-1:0]       wait_q;
  logic                    cmd_ready_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [31:0]             pwdata_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_rdata_q;
  logic                    rsp_err_q;
  logic                    rsp_timeout_q;

  // FSM with registered outputs. cmd_ready_q is raised one cycle before the
  // FSM can accept, so it is low during reset and rises in the first cycle
  // after release. The response handshake also raises it, which lets a new
  // command be taken in the cycle right after the response is consumed.
  // That gives one transfer every four cycles. In ACCESS, PREADY is tested
  // before the timeout threshold, so a completer that answers on the last
  // allowed cycle still gets a normal completion.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      phase_q       <= PHASE_IDLE;
      wait_q        <= '0;
      cmd_ready_q   <= 1'b0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            paddr_q     <= cmd_addr_i;
            pwrite_q    <= cmd_write_i;
            pwdata_q    <= cmd_wdata_i;
            cmd_ready_q <= 1'b0;
            phase_q     <= PHASE_SETUP;
            state_q     <= ST_SETUP;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          phase_q <= PHASE_ACCESS;
          wait_q  <= '0;
          state_q <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            rsp_rdata_q   <= pwrite_q ? 32'd0 : prdata_i;
            rsp_err_q     <= pslverr_i;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            phase_q       <= PHASE_IDLE;
            state_q       <= ST_RESP;
          end else if (wait_q == WAIT_LAST) begin
            rsp_rdata_q   <= 32'd0;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            phase_q       <= PHASE_IDLE;
            state_q       <= ST_RESP;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          phase_q <= PHASE_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign paddr_o       = paddr_q;
  assign pwrite_o      = pwrite_q;
  assign pwdata_o      = pwdata_q;
  assign psel_o        = phase_q.psel;
  assign penable_o     = phase_q.penable;

endmodule

// File: tb/tb_conv_apb_master.sv
// Directed bench for conv_apb_master with TIMEOUT_CYCLES=4.
// Cycle k of a transfer is the cycle after the k-th rising edge that
// follows the command handshake. Inputs are driven, and outputs sampled,
// 1 time unit after each rising edge.
module tb_conv_apb_master;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_write_i;
  logic [31:0] cmd_addr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] paddr_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic        psel_o;
  logic        penable_o;
  logic [31:0] prdata_i;
  logic        pready_i;
  logic        pslverr_i;

  int total = 0;
  int bad   = 0;

  conv_apb_master #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  // 10-unit clock period
  always #5 clk_i = ~clk_i;

  // Advance to 1 unit after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive the command and response-side inputs together
  task automatic applyStimulus(input logic valid, input logic write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic rspReady);
    cmd_valid_i = valid;
    cmd_write_i = write;
    cmd_addr_i  = addr;
    cmd_wdata_i = wdata;
    rsp_ready_i = rspReady;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence of transfers
  initial begin
    reset_i   = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    prdata_i  = 32'h0;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    repeat (3) tick();

    $display("[TB] reset state");
    checkOutput("rst_cmd_ready", cmd_ready_o, 0);
    checkOutput("rst_rsp_valid", rsp_valid_o, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata_o, 0);
    checkOutput("rst_rsp_err", rsp_err_o, 0);
    checkOutput("rst_rsp_timeout", rsp_timeout_o, 0);
    checkOutput("rst_psel", psel_o, 0);
    checkOutput("rst_penable", penable_o, 0);
    checkOutput("rst_pwrite", pwrite_o, 0);
    checkOutput("rst_paddr", paddr_o, 0);
    checkOutput("rst_pwdata", pwdata_o, 0);

    reset_i = 1'b0;
    tick();
    checkOutput("rel_cmd_ready", cmd_ready_o, 1);

    // Write addr 0x0, data 0x1, completer always ready
    $display("[TB] zero-wait write");
    applyStimulus(1'b1, 1'b1, 32'h0, 32'h1, 1'b0);
    pready_i = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("wr_c1_psel", psel_o, 1);
    checkOutput("wr_c1_penable", penable_o, 0);
    checkOutput("wr_c1_cmd_ready", cmd_ready_o, 0);
    checkOutput("wr_c1_pwrite", pwrite_o, 1);
    checkOutput("wr_c1_pwdata", pwdata_o, 32'h1);
    checkOutput("wr_c1_paddr", paddr_o, 32'h0);
    tick();
    checkOutput("wr_c2_psel", psel_o, 1);
    checkOutput("wr_c2_penable", penable_o, 1);
    checkOutput("wr_c2_rsp_valid", rsp_valid_o, 0);
    tick();
    checkOutput("wr_c3_rsp_valid", rsp_valid_o, 1);
    checkOutput("wr_c3_psel", psel_o, 0);
    checkOutput("wr_c3_penable", penable_o, 0);
    checkOutput("wr_c3_rdata", rsp_rdata_o, 0);
    checkOutput("wr_c3_err", rsp_err_o, 0);
    checkOutput("wr_c3_timeout", rsp_timeout_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checkOutput("wr_c4_rsp_valid", rsp_valid_o, 0);
    checkOutput("wr_c4_cmd_ready", cmd_ready_o, 1);

    // Read addr 0x8, three wait states. PREADY arrives on the fourth ACCESS
    // cycle, which is also the timeout threshold, so completion must be normal.
    $display("[TB] read with three wait states");
    applyStimulus(1'b1, 1'b0, 32'h8, 32'hFFFF_FFFF, 1'b0);
    pready_i = 1'b0;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("rd_c1_paddr", paddr_o, 32'h8);
    checkOutput("rd_c1_pwrite", pwrite_o, 0);
    repeat (3) tick();
    checkOutput("rd_c4_penable", penable_o, 1);
    checkOutput("rd_c4_paddr", paddr_o, 32'h8);
    tick();
    pready_i = 1'b1;
    prdata_i = 32'h0000_1234;
    checkOutput("rd_c5_rsp_valid", rsp_valid_o, 0);
    tick();
    pready_i = 1'b0;
    prdata_i = 32'h0;
    checkOutput("rd_c6_rsp_valid", rsp_valid_o, 1);
    checkOutput("rd_c6_rdata", rsp_rdata_o, 32'h0000_1234);
    checkOutput("rd_c6_err", rsp_err_o, 0);
    checkOutput("rd_c6_timeout", rsp_timeout_o, 0);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checkOutput("rd_c7_rsp_valid", rsp_valid_o, 0);

    // Read that ends with PSLVERR
    $display("[TB] read with slave error");
    applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = 32'hDEAD_BEEF;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) tick();
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    prdata_i  = 32'h0;
    checkOutput("err_c3_rsp_valid", rsp_valid_o, 1);
    checkOutput("err_c3_err", rsp_err_o, 1);
    checkOutput("err_c3_timeout", rsp_timeout_o, 0);
    checkOutput("err_c3_rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Completer never answers: abort after four ACCESS cycles
    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    prdata_i = 32'h5555_5555;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (4) tick();
    checkOutput("to_c5_psel", psel_o, 1);
    checkOutput("to_c5_penable", penable_o, 1);
    checkOutput("to_c5_rsp_valid", rsp_valid_o, 0);
    tick();
    checkOutput("to_c6_rsp_valid", rsp_valid_o, 1);
    checkOutput("to_c6_err", rsp_err_o, 1);
    checkOutput("to_c6_timeout", rsp_timeout_o, 1);
    checkOutput("to_c6_rdata", rsp_rdata_o, 0);
    checkOutput("to_c6_psel", psel_o, 0);
    prdata_i = 32'h0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Response back-pressure with the next command already waiting
    $display("[TB] response back-pressure");
    applyStimulus(1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5, 1'b0);
    pready_i = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    repeat (2) tick();
    pready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_rsp_valid", rsp_valid_o, 1);
      checkOutput("bp_cmd_ready", cmd_ready_o, 0);
      checkOutput("bp_rdata", rsp_rdata_o, 0);
      checkOutput("bp_err", rsp_err_o, 0);
      tick();
    end
    checkOutput("bp_end_rsp_valid", rsp_valid_o, 1);
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checkOutput("bp_hs_rsp_valid", rsp_valid_o, 0);
    checkOutput("bp_hs_cmd_ready", cmd_ready_o, 1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("bp_next_psel", psel_o, 1);
    checkOutput("bp_next_paddr", paddr_o, 32'h40);
    checkOutput("bp_next_pwrite", pwrite_o, 0);

    // Reset during ACCESS abandons the second command
    $display("[TB] reset during access");
    tick();
    checkOutput("mr_access_penable", penable_o, 1);
    reset_i = 1'b1;
    tick();
    checkOutput("mr_psel", psel_o, 0);
    checkOutput("mr_penable", penable_o, 0);
    checkOutput("mr_rsp_valid", rsp_valid_o, 0);
    checkOutput("mr_cmd_ready", cmd_ready_o, 0);
    reset_i = 1'b0;
    tick();
    checkOutput("mr_rel_cmd_ready", cmd_ready_o, 1);
    checkOutput("mr_rel_rsp_valid", rsp_valid_o, 0);
    checkOutput("mr_rel_psel", psel_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_apb_master.md
CONV_APB_MASTER -- requirements
Module: conv_apb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, sets the maximum ACCESS-phase cycles waited for PREADY before abort; legal range 2..65535.
REQ-002 Parameter ADDR_WIDTH, default 32, sets the width of CMD_ADDR and PADDR.
REQ-003 CLK  input  1  single clock for all logic; rising-edge only.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  command accepted when CMD_VALID and CMD_READY are both high.
REQ-007 CMD_WRITE  input  1  1 = APB write, 0 = APB read.
REQ-008 CMD_ADDR  input  ADDR_WIDTH  target register address.
REQ-009 CMD_WDATA  input  32  write data; ignored for reads.
REQ-010 RSP_VALID  output  1  response available.
REQ-011 RSP_READY  input  1  response consumed when RSP_VALID and RSP_READY are both high.
REQ-012 RSP_RDATA  output  32  read data; 0 for writes and for timeouts.
REQ-013 RSP_ERR  output  1  PSLVERR captured from the completer, or timeout.
REQ-014 RSP_TIMEOUT  output  1  transfer aborted by timeout.
REQ-015 PADDR, PWRITE, PWDATA  outputs  ADDR_WIDTH/1/32  APB address, direction and write data.
REQ-016 PSEL, PENABLE  outputs  1/1  APB select and enable.
REQ-017 PRDATA, PREADY, PSLVERR  inputs  32/1/1  APB completer response.

Function
REQ-018 The block SHALL implement a four-state FSM: IDLE, SETUP, ACCESS and RESP.
REQ-019 CMD_READY SHALL be high only in IDLE; a handshake there SHALL register CMD_ADDR, CMD_WRITE and CMD_WDATA and move the FSM to SETUP.
REQ-020 SETUP SHALL last exactly one cycle, with PSEL=1, PENABLE=0 and PADDR, PWRITE and PWDATA driven from the registered command; the FSM then moves to ACCESS.
REQ-021 ACCESS SHALL drive PSEL=1 and PENABLE=1 and hold PADDR, PWRITE and PWDATA stable until exit.
REQ-022 In ACCESS with PREADY=1, the block SHALL capture RSP_RDATA (PRDATA for reads, 0 for writes) and RSP_ERR=PSLVERR, set RSP_TIMEOUT=0, drop PSEL and PENABLE next cycle, and enter RESP.
REQ-023 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-024 When the wait counter reaches TIMEOUT_CYCLES-1 with PREADY=0, the block SHALL abort: enter RESP with RSP_ERR=1, RSP_TIMEOUT=1 and RSP_RDATA=0.
REQ-025 If PREADY=1 arrives in the same cycle as the timeout threshold, PREADY SHALL win and no timeout is flagged.
REQ-026 RSP_VALID SHALL be high exactly in RESP; RSP_RDATA, RSP_ERR and RSP_TIMEOUT SHALL hold until the handshake, after which the FSM returns to IDLE.
REQ-027 Minimum latency SHALL be: command accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2, RSP_VALID at cycle 3 (zero-wait completer); minimum throughput is one transfer per 4 cycles.
REQ-028 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-029 PSEL SHALL never be high outside SETUP and ACCESS, and PENABLE never outside ACCESS.

Reset
REQ-030 While RESET=1, the FSM SHALL be in IDLE and the wait counter 0, with outputs at: CMD_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, RSP_TIMEOUT=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-031 CMD_READY SHALL rise in the first cycle after RESET deasserts.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer, generate no response, and deassert PSEL and PENABLE on the next edge.

Structure
REQ-033 The FSM state encoding and the APB phase constants SHALL reside in shared package conv_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the timeout counter width SHALL be derived from TIMEOUT_CYCLES.

Verification
REQ-035 The bench SHALL cover: write addr 0x0, data 0x1, PREADY tied 1 -> PSEL high on cycles 1–2, PENABLE on cycle 2, RSP_VALID on cycle 3 with RDATA=0 and ERR=0.
REQ-036 The bench SHALL cover: read addr 0x8, completer returns PRDATA=0x0000_1234 after 3 wait states -> RSP_RDATA=0x1234 and RSP_VALID on cycle 6.
REQ-037 The bench SHALL cover: read with PSLVERR=1 on the PREADY cycle -> RSP_ERR=1, RSP_TIMEOUT=0, PRDATA captured.
REQ-038 The bench SHALL cover: TIMEOUT_CYCLES=4, PREADY held 0 -> abort after 4 ACCESS cycles with RSP_ERR=1, RSP_TIMEOUT=1 and RSP_RDATA=0; PREADY=1 on the 4th cycle -> normal completion.
REQ-039 The bench SHALL cover: RSP_READY held 0 for 10 cycles with CMD_VALID high -> CMD_READY stays 0, response is stable, and the next command starts in the cycle after the handshake.
REQ-040 The bench SHALL cover: RESET pulsed during ACCESS -> PSEL=0 and RSP_VALID=0 next cycle, then CMD_READY=1 after release.
